hash_target_checker: RTL and testbench
======================================

Name: hash_target_checker

Overview:
- Sequencer that decides whether a multi-byte block hash is strictly below a difficulty target.
- Time-shares a single 8-bit equal/greater/less comparator, comparing one byte per cycle, most significant byte first.
- Terminates early on the first unequal byte.
- Sits between the hash core and the nonce/mining controller; the controller waits for the done pulse.

Parameters:
N_BYTES, 4, number of bytes in hash and target (total width N_BYTES*8); legal range 1..32
CNT_W, 16, width of the hit counter (used only with HTC_STATS_EN)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a compare; accepted only when ready=1
hash  input  N_BYTES*8  candidate hash, sampled on the accept cycle
target  input  N_BYTES*8  difficulty target, sampled on the accept cycle
ready  output  1  high in IDLE; block can accept start
done  output  1  one-cycle pulse: result fields valid
below  output  1  hash < target (unsigned)
equal  output  1  hash == target
bytes_cmp  output  $clog2(N_BYTES+1)  number of byte comparisons used by the last job
hit_count  output  CNT_W  count of jobs with below=1 (0 without HTC_STATS_EN)

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst). All state changes occur on the rising edge of clk.
- Reset values: state=IDLE, ready=1, done=0, below=0, equal=0, bytes_cmp=0, hit_count=0.
- Reset mid-operation: an in-flight job is discarded and no done pulse is produced.
- FSM: IDLE -> COMPARE -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - On start=1: latch hash and target into internal registers, set idx=N_BYTES-1, go to COMPARE.
  - Inputs are ignored after the accept cycle.
- COMPARE:
  - Byte idx of the latched hash and target drives the shared comparator (combinational).
  - If lt or gt: record below=lt, equal=0, go to DONE.
  - Else if idx==0: record below=0, equal=1, go to DONE.
  - Else: decrement idx and stay in COMPARE.
  - bytes_cmp = number of COMPARE cycles spent, registered with the result.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Result hold: below, equal and bytes_cmp hold until the next done pulse. They are not cleared when a new job is accepted.
- Latency: with accept at cycle 0 and k bytes compared (1<=k<=N_BYTES), done is high in cycle k+1. Worst case is N_BYTES+1. The next start can be accepted at cycle k+2.
- Start while ready=0 is ignored. It is not queued and does not affect the in-flight job.
- Arithmetic: comparison is unsigned, big-endian; byte N_BYTES-1 (bits [N_BYTES*8-1 -: 8]) is most significant.
- N_BYTES=1 is legal: always one COMPARE cycle.
- below and equal are never both 1.

Optional Feature:
- Macro: HTC_STATS_EN.
- Defined:
  - hit_count increments by 1 in the DONE cycle when below=1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by rst.
- Undefined: counter logic is omitted; hit_count is tied to 0. The port list is unchanged.

Decomposition:
- Package htc_pkg: FSM state enum (IDLE, COMPARE, DONE) and a BYTE_W=8 constant.
- One sub-module, byte_cmp: 8-bit a/b in; eq, gt, lt out; purely combinational; instantiated exactly once and muxed by idx.

Test Plan:
- N_BYTES=4, hash=0x00FFFFFF, target=0x01000000, start at cycle 0 -> done at cycle 2, below=1, equal=0, bytes_cmp=1.
- hash=target=0xDEADBEEF -> done at cycle 5, below=0, equal=1, bytes_cmp=4.
- hash=0x12345679, target=0x12345678 -> done at cycle 5, below=0, equal=0, bytes_cmp=4. Swap operands -> below=1.
- Start accepted; at cycle 1 pulse start=1 with hash=0 -> ignored; original result reported; exactly one done pulse.
- Assert rst at cycle 2 of a 4-byte-equal job -> no done pulse, ready=1 at the next cycle, all outputs at reset values. A new job then completes normally.
- HTC_STATS_EN, CNT_W=2: run five below=1 jobs and one equal job -> hit_count sequence 1,2,3,3,3 (saturates). Without the macro, hit_count stays 0.

Source files
------------

// File: rtl/hash_target_checker_pkg.sv
// Shared types and constants for the hash/target comparison sequencer.
// The optional hit counter is enabled with the HTC_STATS_EN macro.
package htc_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } htc_state_e;

endpackage

// File: rtl/hash_target_checker_if.sv
// Bus between the mining controller (master) and the hash/target checker
// (slave): start handshake, operands and the registered result fields.
interface hash_target_checker_if #(
  parameter int N_BYTES = 4,
  parameter int CNT_W   = 16
);

  localparam int BC_W = $clog2(N_BYTES + 1);

  logic                   start;
  logic [N_BYTES*8-1:0]   hash;
  logic [N_BYTES*8-1:0]   target;
  logic                   ready;
  logic                   done;
  logic                   below;
  logic                   equal;
  logic [BC_W-1:0]        bytes_cmp;
  logic [CNT_W-1:0]       hit_count;

  modport master (
    output start, hash, target,
    input  ready, done, below, equal, bytes_cmp, hit_count
  );

  modport slave (
    input  start, hash, target,
    output ready, done, below, equal, bytes_cmp, hit_count
  );

endinterface

// File: rtl/hash_target_checker_byte_cmp.sv
// Single 8-bit unsigned comparator, time-shared by the checker across all
// bytes of the hash. Purely combinational.
module byte_cmp
  import htc_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic              eq,
  output logic              gt,
  output logic              lt
);

  // Exactly one of eq/gt/lt is high for any operand pair
  always_comb begin
    eq = (a == b);
    gt = (a > b);
    lt = (a < b);
  end

endmodule

// File: rtl/hash_target_checker.sv
// Decides whether a multi-byte hash is strictly below a difficulty target,
// comparing one byte per cycle from the most significant byte down and
// stopping at the first unequal byte. Define HTC_STATS_EN to enable the
// saturating count of jobs that ended with below=1.
module hash_target_checker
  import htc_pkg::*;
#(
  parameter int N_BYTES = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hash_target_checker_if.slave   bus
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int BC_W  = $clog2(N_BYTES + 1);

  htc_state_e                       state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [N_BYTES-1:0][BYTE_W-1:0]   hash_q, hash_d;
  logic [N_BYTES-1:0][BYTE_W-1:0]   target_q, target_d;
  logic                             below_q, below_d;
  logic                             equal_q, equal_d;
  logic [BC_W-1:0]                  bytes_cmp_q, bytes_cmp_d;

  logic [BYTE_W-1:0]                cmp_a;
  logic [BYTE_W-1:0]                cmp_b;
  logic                             cmp_eq;
  logic                             cmp_gt;
  logic                             cmp_lt;

  // Route the current byte of the latched operands to the shared comparator
  always_comb begin
    cmp_a = hash_q[idx_q];
    cmp_b = target_q[idx_q];
  end

  byte_cmp u_byte_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .eq (cmp_eq),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  // Next-state logic: accept a job, walk the bytes MSB first, then pulse done
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hash_d      = hash_q;
    target_d    = target_q;
    below_d     = below_q;
    equal_d     = equal_q;
    bytes_cmp_d = bytes_cmp_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          hash_d   = bus.hash;
          target_d = bus.target;
          idx_d    = IDX_W'(N_BYTES - 1);
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        if (cmp_lt || cmp_gt) begin
          below_d     = cmp_lt;
          equal_d     = 1'b0;
          bytes_cmp_d = BC_W'(N_BYTES) - BC_W'(idx_q);
          state_d     = DONE;
        end else if (idx_q == '0) begin
          below_d     = 1'b0;
          equal_d     = 1'b1;
          bytes_cmp_d = BC_W'(N_BYTES);
          state_d     = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any job in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hash_q      <= '0;
      target_q    <= '0;
      below_q     <= 1'b0;
      equal_q     <= 1'b0;
      bytes_cmp_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hash_q      <= hash_d;
      target_q    <= target_d;
      below_q     <= below_d;
      equal_q     <= equal_d;
      bytes_cmp_q <= bytes_cmp_d;
    end
  end

  // Status outputs decoded from state; results come straight from registers
  always_comb begin
    bus.ready     = (state_q == IDLE);
    bus.done      = (state_q == DONE);
    bus.below     = below_q;
    bus.equal     = equal_q;
    bus.bytes_cmp = bytes_cmp_q;
  end

`ifdef HTC_STATS_EN
  logic [CNT_W-1:0] hit_count_q, hit_count_d;

  // Count finished jobs with below=1, sticking at the maximum value
  always_comb begin
    hit_count_d = hit_count_q;
    if ((state_q == DONE) && below_q && (hit_count_q != {CNT_W{1'b1}})) begin
      hit_count_d = hit_count_q + 1'b1;
    end
  end

  // Hit counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q <= '0;
    end else begin
      hit_count_q <= hit_count_d;
    end
  end

  assign bus.hit_count = hit_count_q;
`else
  assign bus.hit_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_hash_target_checker.sv
// Self-checking bench for hash_target_checker (N_BYTES=4, CNT_W=2).
// Directed cases plus randomized jobs checked against a plain-arithmetic
// reference; hit_count expectations follow HTC_STATS_EN.
module tb_hash_target_checker;

  localparam int N_BYTES = 4;
  localparam int CNT_W   = 2;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;
  int hitsModel = 0;

  hash_target_checker_if #(.N_BYTES(N_BYTES), .CNT_W(CNT_W)) bus ();

  hash_target_checker #(.N_BYTES(N_BYTES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait ever escapes its bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: number of bytes examined is set by the highest differing byte
  function automatic int bytesUsed(input logic [31:0] h, input logic [31:0] t);
    logic [31:0] diff;
    int k;
    diff = h ^ t;
    if (diff == 0) return N_BYTES;
    k = 0;
    while (diff != 0) begin
      diff = diff >> 8;
      k++;
    end
    return N_BYTES - k + 1;
  endfunction

  task automatic bumpHits(input logic wasBelow);
`ifdef HTC_STATS_EN
    if (wasBelow && hitsModel < (1 << CNT_W) - 1) hitsModel++;
`else
    hitsModel = 0;
`endif
  endtask

  task automatic waitReady(input string tag);
    int w = 0;
    while (!bus.ready && w < 20) begin
      nextCycle();
      w++;
    end
    if (!bus.ready) checkOutput({tag, "_ready_wait"}, 32'(bus.ready), 32'd1);
  endtask

  // Run one job and check latency, results and the post-done cycle
  task automatic applyStimulus(input logic [31:0] h, input logic [31:0] t,
                               input string tag);
    int n;
    int k;
    logic expBelow;
    k = bytesUsed(h, t);
    expBelow = (h < t);
    waitReady(tag);
    bus.start  = 1'b1;
    bus.hash   = h;
    bus.target = t;
    nextCycle();
    bus.start  = 1'b0;
    bus.hash   = $urandom;
    bus.target = $urandom;
    n = 1;
    while (!bus.done && n < 12) begin
      nextCycle();
      n++;
    end
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(n), 32'(k + 1));
    checkOutput({tag, "_below"}, 32'(bus.below), 32'(expBelow));
    checkOutput({tag, "_equal"}, 32'(bus.equal), 32'(h == t));
    checkOutput({tag, "_bytes_cmp"}, 32'(bus.bytes_cmp), 32'(k));
    bumpHits(expBelow);
    nextCycle();
    checkOutput({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
    checkOutput({tag, "_hit_count"}, 32'(bus.hit_count), 32'(hitsModel));
  endtask

  // Randomized target: fully random, identical, or sharing upper bytes
  function automatic logic [31:0] makeTarget(input logic [31:0] h);
    logic [31:0] t;
    int sel;
    int pos;
    sel = $urandom_range(0, 3);
    t = h;
    if (sel == 0) begin
      t = $urandom;
    end else if (sel != 1) begin
      pos = $urandom_range(0, N_BYTES - 1);
      t[pos*8 +: 8] = 8'($urandom);
    end
    return t;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(bus.ready), 32'd1);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_below"}, 32'(bus.below), 32'd0);
    checkOutput({tag, "_equal"}, 32'(bus.equal), 32'd0);
    checkOutput({tag, "_bytes_cmp"}, 32'(bus.bytes_cmp), 32'd0);
    checkOutput({tag, "_hit_count"}, 32'(bus.hit_count), 32'd0);
  endtask

  initial begin
    int pulses;
    logic capBelow;
    logic capEqual;
    logic [31:0] capBytes;
    logic [31:0] h;
    logic [31:0] t;

    bus.start  = 1'b0;
    bus.hash   = '0;
    bus.target = '0;
    rst = 1'b1;
    nextCycle();
    nextCycle();
    checkResetOutputs("reset");
    rst = 1'b0;
    nextCycle();

    // Directed cases from the test plan
    applyStimulus(32'h00FFFFFF, 32'h01000000, "msb_below");
    applyStimulus(32'hDEADBEEF, 32'hDEADBEEF, "all_equal");
    applyStimulus(32'h12345679, 32'h12345678, "lsb_above");
    applyStimulus(32'h12345678, 32'h12345679, "lsb_below");
    applyStimulus(32'hFF000000, 32'h00FFFFFF, "msb_above");
    applyStimulus(32'h00000000, 32'h00000000, "zero_equal");

    // Start while busy must be ignored and not queued
    waitReady("busy");
    bus.start  = 1'b1;
    bus.hash   = 32'h12345678;
    bus.target = 32'h12345679;
    nextCycle();
    bus.hash   = 32'h00000000;
    bus.target = 32'hFFFFFFFF;
    pulses = 0;
    capBelow = 1'b0;
    capEqual = 1'b0;
    capBytes = '0;
    for (int c = 1; c <= 12; c++) begin
      if (bus.done) begin
        pulses++;
        capBelow = bus.below;
        capEqual = bus.equal;
        capBytes = 32'(bus.bytes_cmp);
      end
      nextCycle();
      bus.start = 1'b0;
    end
    checkOutput("busy_pulses", 32'(pulses), 32'd1);
    checkOutput("busy_below", 32'(capBelow), 32'd1);
    checkOutput("busy_equal", 32'(capEqual), 32'd0);
    checkOutput("busy_bytes_cmp", capBytes, 32'd4);
    bumpHits(1'b1);
    checkOutput("busy_hit_count", 32'(bus.hit_count), 32'(hitsModel));

    // Randomized jobs against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      h = $urandom;
      t = makeTarget(h);
      applyStimulus(h, t, "rand");
    end

    // Reset in the middle of an all-equal job discards it
    waitReady("midrst");
    bus.start  = 1'b1;
    bus.hash   = 32'hDEADBEEF;
    bus.target = 32'hDEADBEEF;
    nextCycle();
    bus.start = 1'b0;
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    hitsModel = 0;
    checkResetOutputs("midrst");
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done) pulses++;
      nextCycle();
    end
    checkOutput("midrst_no_done", 32'(pulses), 32'd0);
    applyStimulus(32'hCAFEF00D, 32'hCAFEF00E, "post_rst");

    // Enough below jobs to reach counter saturation, then an equal job
    for (int i = 0; i < 5; i++) begin
      h = $urandom_range(0, 32'h7FFFFFFF);
      t = h + 32'd1 + 32'($urandom_range(0, 1000));
      applyStimulus(h, t, "sat");
    end
    applyStimulus(32'h0BADBEEF, 32'h0BADBEEF, "sat_equal");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
